// File: rtl/bitops_pkg.sv
// Shared types for the bitwise logic pipeline: op encoding and counter width.
package bitops_pkg;

    typedef enum logic [2:0] {
        OP_PASS,
        OP_INV,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NAND,
        OP_NOR,
        OP_XNOR
    } op_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/bitops_lane.sv
// One lane of the logic unit: applies the selected op between a lane of A and the shared mask.
module bitops_lane
    import bitops_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = a;
        case (op)
            OP_PASS: y = a;
            OP_INV:  y = ~a;
            OP_AND:  y = a & m;
            OP_OR:   y = a | m;
            OP_XOR:  y = a ^ m;
            OP_NAND: y = ~(a & m);
            OP_NOR:  y = ~(a | m);
            OP_XNOR: y = ~(a ^ m);
            default: y = a;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/bitops_pipe.sv
// Pipelined LANES x WIDTH bitwise unit: op result captured in stage 1, stages 2..DEPTH delay it,
// stall-all valid/ready flow control and a wrapping count of completed output transfers.
module bitops_pipe
    import bitops_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0]       in_mask,
    input  op_e                    in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic [LANES-1:0]       out_zero,
    output logic [CNT_W-1:0]       xfer_count
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $fatal(1, "bitops_pipe: DEPTH must be in 1..4");
    end

    logic [LANES*WIDTH-1:0]              w_y;
    logic [LANES-1:0]                    w_z;
    logic                                w_adv;
    logic [DEPTH:1]                      r_vld_pipe;
    logic [DEPTH:1][LANES*WIDTH-1:0]     r_y;
    logic [DEPTH:1][LANES-1:0]           r_z;
    logic [DEPTH:1]                      w_vld_in;
    logic [DEPTH:1][LANES*WIDTH-1:0]     w_y_in;
    logic [DEPTH:1][LANES-1:0]           w_z_in;
    logic [CNT_W-1:0]                    r_cnt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bitops_lane #(.WIDTH(WIDTH)) u_lane (
            .a    (in_a[l*WIDTH +: WIDTH]),
            .m    (in_mask),
            .op   (in_op),
            .y    (w_y[l*WIDTH +: WIDTH]),
            .zero (w_z[l])
        );
    end

    // Stage 1 only loads new data on a real beat; later stages copy their predecessor.
    for (genvar s = 1; s <= DEPTH; s++) begin : g_stage_in
        if (s == 1) begin : g_first
            assign w_vld_in[s] = in_valid;
            assign w_y_in[s]   = in_valid ? w_y : r_y[s];
            assign w_z_in[s]   = in_valid ? w_z : r_z[s];
        end else begin : g_rest
            assign w_vld_in[s] = r_vld_pipe[s-1];
            assign w_y_in[s]   = r_y[s-1];
            assign w_z_in[s]   = r_z[s-1];
        end
    end

    assign w_adv    = !r_vld_pipe[DEPTH] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_y        <= '0;
            r_z        <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= w_vld_in;
            r_y        <= w_y_in;
            r_z        <= w_z_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_vld_pipe[DEPTH] && out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_vld_pipe[DEPTH];
    assign out_y      = r_y[DEPTH];
    assign out_zero   = r_z[DEPTH];
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_bitops_pipe.sv
// Self-checking bench for bitops_pipe: default instance plus a LANES=2 instance, checked against
// an arithmetic reference model and an in-order scoreboard.
module tb_bitops_pipe;
    import bitops_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_a, in_mask, out_y;
    op_e         in_op;
    logic [0:0]  out_zero;
    logic [15:0] xfer_count;

    logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [7:0]  d2_in_a, d2_out_y;
    logic [3:0]  d2_in_mask;
    op_e         d2_in_op;
    logic [1:0]  d2_out_zero;
    logic [15:0] d2_xfer_count;

    int n_chk  = 0;
    int n_pass = 0;

    bitops_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_mask(in_mask), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .xfer_count(xfer_count)
    );

    bitops_pipe #(.WIDTH(4), .LANES(2), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_a(d2_in_a),
        .in_mask(d2_in_mask), .in_op(d2_in_op), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_y(d2_out_y), .out_zero(d2_out_zero), .xfer_count(d2_xfer_count)
    );

    // Reference: each lane is an integer 0..15, inversion is 15 - x.
    function automatic logic [7:0] ref_y(logic [7:0] a, logic [3:0] m, int lanes, op_e op);
        logic [7:0] y;
        int av, mv, r;
        y = '0;
        for (int l = 0; l < lanes; l++) begin
            av = (int'(a) >> (4*l)) % 16;
            mv = int'(m);
            case (op)
                OP_PASS: r = av;
                OP_INV:  r = 15 - av;
                OP_AND:  r = av & mv;
                OP_OR:   r = av | mv;
                OP_XOR:  r = av ^ mv;
                OP_NAND: r = 15 - (av & mv);
                OP_NOR:  r = 15 - (av | mv);
                default: r = 15 - (av ^ mv);
            endcase
            y = y + 8'(r * (1 << (4*l)));
        end
        return y;
    endfunction

    function automatic logic [1:0] ref_z(logic [7:0] y, int lanes);
        logic [1:0] z;
        z = '0;
        for (int l = 0; l < lanes; l++) z[l] = (((int'(y) >> (4*l)) % 16) == 0);
        return z;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; in_valid = 1'b0; d2_in_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1; in_valid = 1'b1; in_a = 4'h3; in_mask = 4'h0; in_op = OP_PASS; out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_in_a = '0; d2_in_mask = '0; d2_in_op = OP_PASS; d2_out_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (out_y !== 4'h0) $display("FAIL reset_out_y got %h exp 0", out_y); else n_pass++;
        n_chk++; if (out_zero !== 1'b0) $display("FAIL reset_out_zero got %b exp 0", out_zero); else n_pass++;
        n_chk++; if (xfer_count !== 16'h0) $display("FAIL reset_count got %h exp 0", xfer_count); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL reset_beat_accepted got %b exp 0", seen); else n_pass++;
    endtask

    task automatic test_inv_latency();
        int lat;
        cyc();
        in_a = 4'h0; in_mask = 4'h0; in_op = OP_INV; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) $display("FAIL t1_accept got %b exp 1", in_ready); else n_pass++;
        cyc();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        n_chk++; if (lat != 2) $display("FAIL t1_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (out_y !== 4'hF) $display("FAIL t1_out_y got %h exp f", out_y); else n_pass++;
        n_chk++; if (out_zero !== 1'b0) $display("FAIL t1_out_zero got %b exp 0", out_zero); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k;
        logic [3:0] ys [2];
        logic       zs [2];
        int         at [2];
        do_reset();
        cyc();
        in_a = 4'hA; in_op = OP_INV; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        cyc();
        in_a = 4'hF;
        @(negedge clk);
        cyc();
        in_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 10 && k < 2; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ys[k] = out_y; zs[k] = out_zero[0]; at[k] = i; k++;
            end
        end
        @(negedge clk);
        n_chk++; if (k != 2) $display("FAIL t2_beats got %0d exp 2", k); else n_pass++;
        n_chk++; if (ys[0] !== 4'h5) $display("FAIL t2_y0 got %h exp 5", ys[0]); else n_pass++;
        n_chk++; if (zs[0] !== 1'b0) $display("FAIL t2_z0 got %b exp 0", zs[0]); else n_pass++;
        n_chk++; if (ys[1] !== 4'h0) $display("FAIL t2_y1 got %h exp 0", ys[1]); else n_pass++;
        n_chk++; if (zs[1] !== 1'b1) $display("FAIL t2_z1 got %b exp 1", zs[1]); else n_pass++;
        n_chk++; if (at[1] != at[0] + 1) $display("FAIL t2_consecutive got %0d exp %0d", at[1], at[0] + 1); else n_pass++;
        n_chk++; if (xfer_count !== 16'd2) $display("FAIL t2_count got %0d exp 2", xfer_count); else n_pass++;
    endtask

    task automatic test_lanes();
        logic [7:0] ta [16];
        logic [3:0] tm [16];
        op_e        to [16];
        exp_t       q [$];
        exp_t       e;
        int         sent, got;
        ta[0] = 8'h3C; tm[0] = 4'hF; to[0] = OP_XOR;
        for (int i = 0; i < 8; i++) begin ta[1+i] = 8'hA5; tm[1+i] = 4'h6; to[1+i] = op_e'(i); end
        ta[9] = 8'h0F; tm[9] = 4'h0; to[9] = OP_PASS;
        for (int i = 10; i < 16; i++) begin
            ta[i] = 8'($urandom); tm[i] = 4'($urandom); to[i] = op_e'($urandom_range(0, 7));
        end
        sent = 0; got = 0;
        cyc();
        d2_in_a = ta[0]; d2_in_mask = tm[0]; d2_in_op = to[0]; d2_in_valid = 1'b1; d2_out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            @(negedge clk);
            if (d2_in_valid && d2_in_ready) begin
                if (sent == 0) begin
                    e.y = 8'hC3; e.z = 2'b00;
                end else begin
                    e.y = ref_y(ta[sent], tm[sent], 2, to[sent]); e.z = ref_z(e.y, 2);
                end
                q.push_back(e); sent++;
            end
            if (d2_out_valid && d2_out_ready) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL t3_extra_beat got y=%h exp none", d2_out_y);
                end else begin
                    e = q.pop_front();
                    if (d2_out_y !== e.y || d2_out_zero !== e.z)
                        $display("FAIL t3_beat%0d got y=%h z=%b exp y=%h z=%b", got, d2_out_y, d2_out_zero, e.y, e.z);
                    else n_pass++;
                end
                got++;
            end
            cyc();
            if (sent < 16) begin
                d2_in_a = ta[sent]; d2_in_mask = tm[sent]; d2_in_op = to[sent];
            end else d2_in_valid = 1'b0;
        end
        n_chk++; if (got != 16) $display("FAIL t3_count got %0d exp 16", got); else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t       q [$];
        exp_t       e;
        int         sent, got, bad_rdy;
        bit         saw_block, hold_bad;
        logic       pv, pr;
        logic [3:0] py;
        logic       pz;
        sent = 0; got = 0; bad_rdy = 0; saw_block = 0; hold_bad = 0; pv = 0; pr = 1; py = 0; pz = 0;
        cyc();
        in_a = 4'($urandom); in_mask = 4'($urandom); in_op = op_e'($urandom_range(0, 7));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            if (in_ready !== (!out_valid || out_ready)) bad_rdy++;
            if (!in_ready) saw_block = 1'b1;
            if (pv && !pr && (out_valid !== 1'b1 || out_y !== py || out_zero[0] !== pz)) hold_bad = 1'b1;
            pv = out_valid; pr = out_ready; py = out_y; pz = out_zero[0];
            if (in_valid && in_ready) begin
                e.y = ref_y({4'h0, in_a}, in_mask, 1, in_op); e.z = ref_z(e.y, 1);
                q.push_back(e); sent++;
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL t4_extra_beat got y=%h exp none", out_y);
                end else begin
                    e = q.pop_front();
                    if (out_y !== e.y[3:0] || out_zero[0] !== e.z[0])
                        $display("FAIL t4_beat%0d got y=%h z=%b exp y=%h z=%b", got, out_y, out_zero, e.y[3:0], e.z[0]);
                    else n_pass++;
                end
                got++;
            end
            cyc();
            if (sent >= 6) in_valid = 1'b0;
            else if (!in_valid || in_ready) begin
                in_a = 4'($urandom); in_mask = 4'($urandom); in_op = op_e'($urandom_range(0, 7));
            end
            out_ready = !(c >= 1 && c < 6);
        end
        n_chk++; if (got != 6) $display("FAIL t4_delivered got %0d exp 6", got); else n_pass++;
        n_chk++; if (bad_rdy != 0) $display("FAIL t4_in_ready_rule got %0d exp 0", bad_rdy); else n_pass++;
        n_chk++; if (saw_block !== 1'b1) $display("FAIL t4_in_ready_low got %b exp 1", saw_block); else n_pass++;
        n_chk++; if (hold_bad !== 1'b0) $display("FAIL t4_hold_stable got %b exp 0", hold_bad); else n_pass++;
        n_chk++; if (q.size() != 0) $display("FAIL t4_lost got %0d exp 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bit   seen;
        int   lat;
        logic [7:0] ey;
        cyc();
        in_a = 4'h6; in_mask = 4'h0; in_op = OP_PASS; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        cyc();
        in_a = 4'h9;
        @(negedge clk);
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (xfer_count !== 16'h0) $display("FAIL t6_count got %h exp 0", xfer_count); else n_pass++;
        seen = out_valid;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL t6_flushed got %b exp 0", seen); else n_pass++;
        cyc();
        in_a = 4'h3; in_mask = 4'h4; in_op = OP_NOR; in_valid = 1'b1;
        ey = ref_y(8'h03, 4'h4, 1, OP_NOR);
        @(negedge clk);
        cyc();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        n_chk++; if (lat != 2) $display("FAIL t6_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (out_y !== ey[3:0]) $display("FAIL t6_out_y got %h exp %h", out_y, ey[3:0]); else n_pass++;
    endtask

    task automatic test_wrap();
        int tb_cnt, bad;
        bit saw;
        do_reset();
        in_a = 4'h1; in_mask = 4'h0; in_op = OP_PASS; in_valid = 1'b1; out_ready = 1'b1;
        tb_cnt = 0; bad = 0; saw = 1'b0;
        for (int i = 0; i < 70000 && tb_cnt < 65536; i++) begin
            @(negedge clk);
            if (xfer_count !== 16'(tb_cnt)) bad++;
            if (xfer_count == 16'hFFFF) saw = 1'b1;
            if (out_valid && out_ready) tb_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (tb_cnt != 65536) $display("FAIL t5_transfers got %0d exp 65536", tb_cnt); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL t5_count_track got %0d exp 0", bad); else n_pass++;
        n_chk++; if (saw !== 1'b1) $display("FAIL t5_reached_ffff got %b exp 1", saw); else n_pass++;
        n_chk++; if (xfer_count !== 16'h0000) $display("FAIL t5_wrap got %h exp 0000", xfer_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_inv_latency();
        test_back_to_back();
        test_lanes();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
